// File: rtl/hamming_univ_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// hamming_shreg_pkg
// Shared types and SECDED helpers for the Hamming-protected universal shift
// register.
//
// Codeword layout (CW = WIDTH + P + 1 bits):
//   bit 0            overall parity over bits 1..WIDTH+P
//   bits 2**k        Hamming parity bits, k = 0..P-1
//   remaining bits   data bits, data[0] at the lowest free position upward
//
// The helpers work on fixed maximum-size vectors so one set of functions
// serves every WIDTH. Supported WIDTH range is 2..56, which keeps the
// codeword strictly inside MAX_CW.
// ----------------------------------------------------------------------------
package hamming_shreg_pkg;

    typedef enum logic [1:0] {
        MODE_SISO = 2'b00,
        MODE_SIPO = 2'b01,
        MODE_PISO = 2'b10,
        MODE_PIPO = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10
    } err_t;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_P      = 7;
    localparam int MAX_CW     = 72;

    // Smallest P with 2**P >= width + P + 1.
    function automatic int calc_p(input int width);
        int p;
        p = 1;
        while ((1 << p) < (width + p + 1)) p++;
        return p;
    endfunction

    function automatic logic is_pow2(input int v);
        return ((v & (v - 1)) == 0);
    endfunction

    function automatic logic [MAX_CW-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                 input int width);
        logic [MAX_CW-1:0] c;
        int                n;
        int                p;
        int                di;
        logic              par;
        p  = calc_p(width);
        n  = width + p;
        c  = '0;
        di = 0;
        for (int i = 1; i < MAX_CW; i++) begin
            if (i <= n && !is_pow2(i)) begin
                c[i] = data[di];
                di++;
            end
        end
        // Parity slots are still zero here, so XOR over every covered
        // position (including the slot itself) gives the parity value.
        for (int k = 0; k < MAX_P; k++) begin
            if (k < p) begin
                par = 1'b0;
                for (int i = 1; i < MAX_CW; i++) begin
                    if (i <= n && ((i >> k) & 1) == 1) par ^= c[i];
                end
                c[1 << k] = par;
            end
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [MAX_P-1:0] syndrome(input logic [MAX_CW-1:0] code,
                                                  input int width);
        logic [MAX_P-1:0] s;
        int               n;
        n = width + calc_p(width);
        s = '0;
        for (int k = 0; k < MAX_P; k++) begin
            for (int i = 1; i < MAX_CW; i++) begin
                if (i <= n && ((i >> k) & 1) == 1) s[k] ^= code[i];
            end
        end
        return s;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] extract(input logic [MAX_CW-1:0] code,
                                                      input int width);
        logic [MAX_DATA_W-1:0] d;
        int                    n;
        int                    di;
        n  = width + calc_p(width);
        d  = '0;
        di = 0;
        for (int i = 1; i < MAX_CW; i++) begin
            if (i <= n && !is_pow2(i)) begin
                d[di] = code[i];
                di++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_univ_shift_reg_if.sv
// ----------------------------------------------------------------------------
// hamming_univ_shift_reg_if
// Control/data bundle for hamming_univ_shift_reg.
//   master : drives enable, mode, dir, load, serial_in, parallel_in, err_clr,
//            inj_mask; observes every output below.
//   slave  : the shift register itself.
// Outputs: serial_out, parallel_out, word_valid, shift_done, err_corrected,
//          err_uncorrectable, err_count, dbg_err (decoder class this cycle),
//          dbg_syn (raw Hamming syndrome).
// inj_mask is XORed into the codeword as it is written on each edge; keep it
// zero in normal use. It exists to exercise the correction path.
//
// Strobe semantics (no backpressure): word_valid and shift_done are
// single-cycle pulses, valid for exactly the cycle after the edge that
// completed the word; the consumer must take them that cycle.
// ----------------------------------------------------------------------------
interface hamming_univ_shift_reg_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    import hamming_shreg_pkg::*;

    localparam int P  = calc_p(WIDTH);
    localparam int CW = WIDTH + P + 1;

    logic                 enable;
    mode_t                mode;
    logic                 dir;
    logic                 load;
    logic                 serial_in;
    logic [WIDTH-1:0]     parallel_in;
    logic                 err_clr;
    logic [CW-1:0]        inj_mask;

    logic                 serial_out;
    logic [WIDTH-1:0]     parallel_out;
    logic                 word_valid;
    logic                 shift_done;
    logic                 err_corrected;
    logic                 err_uncorrectable;
    logic [ERR_CNT_W-1:0] err_count;
    err_t                 dbg_err;
    logic [P-1:0]         dbg_syn;

    modport master (
        output enable, mode, dir, load, serial_in, parallel_in, err_clr, inj_mask,
        input  serial_out, parallel_out, word_valid, shift_done,
               err_corrected, err_uncorrectable, err_count, dbg_err, dbg_syn
    );

    modport slave (
        input  enable, mode, dir, load, serial_in, parallel_in, err_clr, inj_mask,
        output serial_out, parallel_out, word_valid, shift_done,
               err_corrected, err_uncorrectable, err_count, dbg_err, dbg_syn
    );

endinterface

// File: rtl/hamming_univ_shift_reg_secded_codec.sv
// ----------------------------------------------------------------------------
// secded_codec
// Combinational SECDED encoder plus decoder/corrector.
// Ports:
//   i_data  WIDTH  data to encode          -> o_code CW  codeword
//   i_code  CW     stored codeword         -> o_data WIDTH corrected data
//   o_err          ERR_NONE / ERR_SINGLE / ERR_DOUBLE
//   o_syn   P      Hamming syndrome of i_code
// On a double error o_data carries the raw (uncorrected) data bits.
// ----------------------------------------------------------------------------
module secded_codec
    import hamming_shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int P     = calc_p(WIDTH),
    localparam int CW    = WIDTH + P + 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_code,
    input  logic [CW-1:0]    i_code,
    output logic [WIDTH-1:0] o_data,
    output err_t             o_err,
    output logic [P-1:0]     o_syn
);

    localparam int NPOS = WIDTH + P;

    logic [MAX_DATA_W-1:0] w_data_ext;
    logic [MAX_CW-1:0]     w_code_enc;
    logic [MAX_CW-1:0]     w_code_ext;
    logic [MAX_CW-1:0]     w_fixed;
    logic [MAX_P-1:0]      w_syn_full;
    logic [MAX_DATA_W-1:0] w_data_full;
    logic                  w_ov;
    logic                  w_unused;

    assign w_data_ext = MAX_DATA_W'(i_data);
    assign w_code_enc = encode(w_data_ext, WIDTH);
    assign o_code     = w_code_enc[CW-1:0];

    assign w_code_ext = MAX_CW'(i_code);
    assign w_syn_full = syndrome(w_code_ext, WIDTH);
    assign w_ov       = ^i_code;

    // Overall parity odd -> odd number of flips: one flip at position
    // syndrome (0 = the overall bit itself). A syndrome pointing past the
    // codeword can only come from a multi-bit flip, so it is treated as
    // uncorrectable. Parity even with a non-zero syndrome is a double error.
    always_comb begin
        w_fixed = w_code_ext;
        o_err   = ERR_NONE;
        if (w_ov) begin
            if (int'(w_syn_full) <= NPOS) begin
                o_err               = ERR_SINGLE;
                w_fixed[w_syn_full] = ~w_code_ext[w_syn_full];
            end else begin
                o_err = ERR_DOUBLE;
            end
        end else if (w_syn_full != '0) begin
            o_err = ERR_DOUBLE;
        end
    end

    assign w_data_full = extract(w_fixed, WIDTH);
    assign o_data      = w_data_full[WIDTH-1:0];
    assign o_syn       = w_syn_full[P-1:0];

    assign w_unused = ^{w_code_enc[MAX_CW-1:CW], w_data_full[MAX_DATA_W-1:WIDTH]};

endmodule

// File: rtl/hamming_univ_shift_reg.sv
// ----------------------------------------------------------------------------
// hamming_univ_shift_reg
// Universal shift register (SISO/SIPO/PISO/PIPO) whose state is stored as a
// SECDED codeword. The codeword is decoded every cycle; single-bit errors are
// corrected and scrubbed back on the next edge, double-bit errors raise a
// sticky flag and freeze storage until a parallel load overwrites it.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active low
//   bus  hamming_univ_shift_reg_if.slave (controls, data, strobes, errors)
// ----------------------------------------------------------------------------
module hamming_univ_shift_reg
    import hamming_shreg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    hamming_univ_shift_reg_if.slave  bus
);

    localparam int P     = calc_p(WIDTH);
    localparam int CW    = WIDTH + P + 1;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic [CW-1:0]        r_code;
    logic [CNT_W-1:0]     r_cnt;
    mode_t                r_mode;
    logic                 r_piso_armed;
    logic                 r_word_valid;
    logic                 r_shift_done;
    logic                 r_err_flag;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0]     w_d;
    logic [WIDTH-1:0]     w_nd;
    logic [WIDTH-1:0]     w_shifted;
    logic [CW-1:0]        w_next_code;
    err_t                 w_err;
    logic [P-1:0]         w_syn;
    logic                 w_fill;
    logic                 w_load_now;
    logic                 w_shift_now;
    logic                 w_single;
    logic                 w_double;
    logic                 w_write;
    logic                 w_mode_chg;
    logic                 w_counting;
    logic [CNT_W-1:0]     w_cnt_base;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_wrap;
    logic                 w_armed_base;
    logic                 w_done;

    secded_codec #(.WIDTH(WIDTH)) u_codec (
        .i_data (w_nd),
        .o_code (w_next_code),
        .i_code (r_code),
        .o_data (w_d),
        .o_err  (w_err),
        .o_syn  (w_syn)
    );

    // Next data word. Serial-in modes shift serial_in in; PISO fills with 0.
    always_comb begin
        w_nd        = w_d;
        w_load_now  = 1'b0;
        w_shift_now = 1'b0;
        w_fill      = 1'b0;
        if (bus.mode == MODE_SISO || bus.mode == MODE_SIPO) w_fill = bus.serial_in;
        w_shifted = bus.dir ? {w_fill, w_d[WIDTH-1:1]} : {w_d[WIDTH-2:0], w_fill};
        if (bus.enable) begin
            case (bus.mode)
                MODE_SISO, MODE_SIPO: begin
                    w_nd        = w_shifted;
                    w_shift_now = 1'b1;
                end
                MODE_PISO: begin
                    if (bus.load) begin
                        w_nd       = bus.parallel_in;
                        w_load_now = 1'b1;
                    end else begin
                        w_nd        = w_shifted;
                        w_shift_now = 1'b1;
                    end
                end
                MODE_PIPO: begin
                    if (bus.load) begin
                        w_nd       = bus.parallel_in;
                        w_load_now = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_single = (w_err == ERR_SINGLE);
    assign w_double = (w_err == ERR_DOUBLE);
    // A double error freezes everything except an enabled parallel load.
    assign w_write  = !w_double || w_load_now;

    // Bit counter: restarts on load or mode change; a shift in the same
    // cycle as the mode change is counted as the first bit of the new word.
    assign w_mode_chg   = (bus.mode != r_mode);
    assign w_counting   = w_shift_now && (bus.mode == MODE_SIPO || bus.mode == MODE_PISO);
    assign w_cnt_base   = (w_load_now || w_mode_chg) ? '0 : r_cnt;
    assign w_wrap       = w_counting && (w_cnt_base == CNT_LAST);
    assign w_cnt_next   = !w_counting ? w_cnt_base :
                          (w_wrap ? '0 : w_cnt_base + CNT_W'(1));
    // shift_done fires once per PISO load, not on every later wrap.
    assign w_armed_base = w_mode_chg ? 1'b0 : r_piso_armed;
    assign w_done       = w_wrap && (bus.mode == MODE_PISO) && w_armed_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code       <= '0;
            r_cnt        <= '0;
            r_mode       <= MODE_SISO;
            r_piso_armed <= 1'b0;
            r_word_valid <= 1'b0;
            r_shift_done <= 1'b0;
            r_err_flag   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_code <= (w_write ? w_next_code : r_code) ^ bus.inj_mask;
            r_mode <= bus.mode;

            if (w_write) begin
                r_cnt        <= w_cnt_next;
                r_word_valid <= w_wrap && (bus.mode == MODE_SIPO);
                r_shift_done <= w_done;
                if (w_load_now)  r_piso_armed <= (bus.mode == MODE_PISO);
                else if (w_done) r_piso_armed <= 1'b0;
                else             r_piso_armed <= w_armed_base;
            end else begin
                r_word_valid <= 1'b0;
                r_shift_done <= 1'b0;
            end

            // A new error in the clearing cycle takes priority over err_clr.
            if (w_double)         r_err_flag <= 1'b1;
            else if (bus.err_clr) r_err_flag <= 1'b0;

            if (w_single) begin
                if (bus.err_clr)               r_err_count <= ERR_CNT_W'(1);
                else if (r_err_count != ERR_MAX) r_err_count <= r_err_count + ERR_CNT_W'(1);
            end else if (bus.err_clr) begin
                r_err_count <= '0;
            end
        end
    end

    assign bus.serial_out        = bus.dir ? w_d[0] : w_d[WIDTH-1];
    assign bus.parallel_out      = w_d;
    assign bus.word_valid        = r_word_valid;
    assign bus.shift_done        = r_shift_done;
    assign bus.err_corrected     = w_single;
    assign bus.err_uncorrectable = r_err_flag;
    assign bus.err_count         = r_err_count;
    assign bus.dbg_err           = w_err;
    assign bus.dbg_syn           = w_syn;

endmodule

// File: tb/tb_hamming_univ_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_hamming_univ_shift_reg
// Directed bench for hamming_univ_shift_reg. dut_a uses ERR_CNT_W=8 for the
// functional sequence; dut_b uses ERR_CNT_W=2 for counter saturation.
// Inputs change on the falling edge, outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_hamming_univ_shift_reg;
    import hamming_shreg_pkg::*;

    localparam int W  = 8;
    localparam int CW = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hamming_univ_shift_reg_if #(.WIDTH(W), .ERR_CNT_W(8)) bus_a ();
    hamming_univ_shift_reg_if #(.WIDTH(W), .ERR_CNT_W(2)) bus_b ();

    hamming_univ_shift_reg #(.WIDTH(W), .ERR_CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    hamming_univ_shift_reg #(.WIDTH(W), .ERR_CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_a();
        bus_a.enable   = 1'b0;
        bus_a.load     = 1'b0;
        bus_a.err_clr  = 1'b0;
        bus_a.inj_mask = '0;
    endtask

    task automatic shift_a(input logic b);
        bus_a.enable    = 1'b1;
        bus_a.serial_in = b;
        tick();
    endtask

    task automatic load_a(input mode_t m, input logic [W-1:0] v);
        bus_a.mode        = m;
        bus_a.enable      = 1'b1;
        bus_a.load        = 1'b1;
        bus_a.parallel_in = v;
        tick();
        idle_a();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] e;

        bus_a.mode = MODE_SISO; bus_a.dir = 1'b0; bus_a.serial_in = 1'b0;
        bus_a.parallel_in = '0;  idle_a();
        bus_b.mode = MODE_SISO; bus_b.dir = 1'b0; bus_b.serial_in = 1'b0;
        bus_b.parallel_in = '0;  bus_b.enable = 1'b0; bus_b.load = 1'b0;
        bus_b.err_clr = 1'b0;    bus_b.inj_mask = '0;

        // Reset state
        tick(); tick();
        check("rst_pout", bus_a.parallel_out, 8'h00);
        check("rst_sout", bus_a.serial_out, 1'b0);
        check("rst_wv", bus_a.word_valid, 1'b0);
        check("rst_cnt", bus_a.err_count, 8'd0);
        check("rst_flag", bus_a.err_uncorrectable, 1'b0);
        rst = 1'b1;
        tick();

        // 1: SIPO dir=0, 1,0,1,1,0,0,1,0 -> 8'hB2
        bus_a.mode = MODE_SIPO; bus_a.dir = 1'b0;
        tick();
        pat = 8'hB2;
        exp_q.push_back(pat);
        for (int i = W - 1; i >= 0; i--) begin
            shift_a(pat[i]);
            if (i == 1) check("sipo_wv_early", bus_a.word_valid, 1'b0);
        end
        idle_a();
        check("sipo_wv", bus_a.word_valid, 1'b1);
        e = exp_q.pop_front();
        check("sipo_word", bus_a.parallel_out, e);
        tick();
        check("sipo_wv_pulse", bus_a.word_valid, 1'b0);
        check("sipo_hold", bus_a.parallel_out, 8'hB2);

        // SIPO dir=1: first bit in ends at bit 0
        pat = 8'($urandom_range(0, 255));
        bus_a.dir = 1'b1;
        exp_q.push_back(pat);
        for (int i = 0; i < W; i++) shift_a(pat[i]);
        idle_a();
        check("sipo_r_wv", bus_a.word_valid, 1'b1);
        e = exp_q.pop_front();
        check("sipo_r_word", bus_a.parallel_out, e);
        check("sipo_r_sout", bus_a.serial_out, e[0]);
        tick();

        // 2: PISO load 8'hDB, MSB first
        bus_a.dir = 1'b0;
        pat = 8'hDB;
        load_a(MODE_PISO, pat);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(W'(pat[i]));
        for (int i = 0; i < W; i++) begin
            e = exp_q.pop_front();
            check("piso_bit", bus_a.serial_out, e[0]);
            if (i == W - 1) check("piso_done_early", bus_a.shift_done, 1'b0);
            bus_a.enable = 1'b1;
            tick();
        end
        check("piso_done", bus_a.shift_done, 1'b1);
        check("piso_zero", bus_a.serial_out, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        idle_a();
        check("piso_done_once", bus_a.shift_done, 1'b0);
        check("piso_zero_word", bus_a.parallel_out, 8'h00);

        // 3: single-bit error while holding
        load_a(MODE_PIPO, 8'h5A);
        check("pipo_load", bus_a.parallel_out, 8'h5A);
        bus_a.inj_mask = CW'(1 << 5);
        tick();
        bus_a.inj_mask = '0;
        check("se_pulse", bus_a.err_corrected, 1'b1);
        check("se_class", bus_a.dbg_err, ERR_SINGLE);
        check("se_pout", bus_a.parallel_out, 8'h5A);
        tick();
        check("se_pulse_end", bus_a.err_corrected, 1'b0);
        check("se_count", bus_a.err_count, 8'd1);
        check("se_syn_clean", bus_a.dbg_syn, 4'd0);
        check("se_scrubbed", bus_a.parallel_out, 8'h5A);

        // 4: double error. Code bits 3 and 6 carry data bits 0 and 2.
        bus_a.inj_mask = CW'((1 << 3) | (1 << 6));
        tick();
        bus_a.inj_mask = '0;
        check("de_class", bus_a.dbg_err, ERR_DOUBLE);
        check("de_raw", bus_a.parallel_out, 8'h5F);
        bus_a.mode = MODE_SIPO;
        shift_a(1'b1);
        shift_a(1'b1);
        idle_a();
        check("de_frozen", bus_a.parallel_out, 8'h5F);
        check("de_flag", bus_a.err_uncorrectable, 1'b1);
        check("de_no_wv", bus_a.word_valid, 1'b0);
        load_a(MODE_PIPO, 8'hEF);
        check("de_reload", bus_a.parallel_out, 8'hEF);
        check("de_reload_clean", bus_a.dbg_err, ERR_NONE);
        check("de_flag_sticky", bus_a.err_uncorrectable, 1'b1);
        check("de_count_kept", bus_a.err_count, 8'd1);
        bus_a.err_clr = 1'b1;
        tick();
        bus_a.err_clr = 1'b0;
        check("clr_flag", bus_a.err_uncorrectable, 1'b0);
        check("clr_count", bus_a.err_count, 8'd0);

        // 5: SIPO with a gap in enable
        bus_a.mode = MODE_SIPO; bus_a.dir = 1'b0;
        tick();
        pat = 8'($urandom_range(0, 255));
        exp_q.push_back(pat);
        for (int i = W - 1; i >= 4; i--) shift_a(pat[i]);
        idle_a();
        for (int i = 0; i < 4; i++) tick();
        check("gap_wv_idle", bus_a.word_valid, 1'b0);
        for (int i = 3; i >= 1; i--) shift_a(pat[i]);
        check("gap_wv_7th", bus_a.word_valid, 1'b0);
        shift_a(pat[0]);
        idle_a();
        check("gap_wv", bus_a.word_valid, 1'b1);
        e = exp_q.pop_front();
        check("gap_word", bus_a.parallel_out, e);
        tick();

        // 6: reset in the middle of a PISO word with a counted error
        load_a(MODE_PISO, 8'hA5);
        bus_a.inj_mask = CW'(1 << 9);
        tick();
        bus_a.inj_mask = '0;
        tick();
        check("mid_count", bus_a.err_count, 8'd1);
        for (int i = 0; i < 3; i++) shift_a(1'b0);
        idle_a();
        check("mid_word", bus_a.parallel_out, 8'h28);
        #2 rst = 1'b0;
        #1;
        check("arst_pout", bus_a.parallel_out, 8'h00);
        check("arst_sout", bus_a.serial_out, 1'b0);
        check("arst_count", bus_a.err_count, 8'd0);
        check("arst_done", bus_a.shift_done, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_done", bus_a.shift_done, 1'b0);
        check("post_rst_wv", bus_a.word_valid, 1'b0);

        // Saturation at ERR_CNT_W=2
        for (int k = 0; k < 4; k++) begin
            bus_b.inj_mask = CW'(1 << (k + 1));
            tick();
            bus_b.inj_mask = '0;
            check("sat_pulse", bus_b.err_corrected, 1'b1);
            tick();
            if (k == 2) check("sat_reach", bus_b.err_count, 2'd3);
        end
        check("sat_stick", bus_b.err_count, 2'd3);
        check("sat_data", bus_b.parallel_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
